alu_issue_arbiter: RTL and testbench

- Shares one bank of per-thread ALU lanes among NUM_WARPS warp requesters.
- Grants one warp at a time in round-robin order, drives the lanes for one enable cycle, and captures the registered per-lane results.
- Returns results to the granted warp over a valid/ready response channel.
- Sits between the warp schedulers and the alu lane instances in the core.

---
 rtl/alu_issue_arbiter_pkg.sv | 28 ++
 rtl/alu_issue_arbiter_rr_picker.sv | 26 ++
 rtl/alu_issue_arbiter.sv | 114 +++++++++++
 tb/tb_alu_issue_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_arbiter_pkg.sv
// Shared types for the ALU issue path: operand/immediate types, lane opcodes
// and the issue arbiter state encoding.
package alu_issue_arbiter_pkg;

  typedef logic [31:0] data_t;
  typedef logic [11:0] imm12_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_ADDI = 4'd9
  } alu_instruction_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/alu_issue_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at N-1 -> 0. N need not be a power of two.
module rr_picker #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any_valid
);

  logic [W-1:0] sel;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    winner    = '0;
    sel       = '0;
    any_valid = |req;
    for (int unsigned i = N; i > 0; i--) begin
      sel = W'((32'(ptr) + i - 1) % N);
      if (req[sel]) winner = sel;
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of one warp at a time onto a shared bank of ALU lanes,
// returning the captured lane results over a valid/ready response channel.
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_WARPS        = 4,
  parameter int unsigned THREADS_PER_WARP = 4,
  parameter int unsigned WARP_ID_W        = $clog2(NUM_WARPS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_WARPS-1:0]        req_valid,
  output logic [NUM_WARPS-1:0]        req_ready,
  input  alu_instruction_t            req_instruction [NUM_WARPS],
  input  imm12_t                      req_imm12 [NUM_WARPS],
  input  logic [THREADS_PER_WARP-1:0] req_mask [NUM_WARPS],
  input  data_t                       req_rs1 [NUM_WARPS][THREADS_PER_WARP],
  input  data_t                       req_rs2 [NUM_WARPS][THREADS_PER_WARP],
  output logic [THREADS_PER_WARP-1:0] alu_enable,
  output alu_instruction_t            alu_instruction,
  output imm12_t                      alu_imm12,
  output data_t                       alu_rs1 [THREADS_PER_WARP],
  output data_t                       alu_rs2 [THREADS_PER_WARP],
  input  data_t                       alu_out [THREADS_PER_WARP],
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [WARP_ID_W-1:0]        resp_warp,
  output logic [THREADS_PER_WARP-1:0] resp_mask,
  output data_t                       resp_data [THREADS_PER_WARP],
  output logic [31:0]                 issue_count
);

  arb_state_t                  state;
  logic [WARP_ID_W-1:0]        rr_ptr;
  logic [WARP_ID_W-1:0]        winner;
  logic [WARP_ID_W-1:0]        win_q;
  logic                        any_valid;
  alu_instruction_t            instr_q;
  imm12_t                      imm_q;
  logic [THREADS_PER_WARP-1:0] mask_q;
  data_t                       rs1_q [THREADS_PER_WARP];
  data_t                       rs2_q [THREADS_PER_WARP];

  rr_picker #(
    .N (NUM_WARPS),
    .W (WARP_ID_W)
  ) u_picker (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_valid) req_ready[winner] = 1'b1;
  end

  assign alu_enable      = (state == EXEC) ? mask_q : '0;
  assign alu_instruction = instr_q;
  assign alu_imm12       = imm_q;
  assign alu_rs1         = rs1_q;
  assign alu_rs2         = rs2_q;
  assign resp_valid      = (state == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      win_q       <= '0;
      instr_q     <= ALU_ADD;
      imm_q       <= '0;
      mask_q      <= '0;
      resp_warp   <= '0;
      resp_mask   <= '0;
      issue_count <= '0;
      for (int unsigned l = 0; l < THREADS_PER_WARP; l++) begin
        rs1_q[l]     <= '0;
        rs2_q[l]     <= '0;
        resp_data[l] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            instr_q <= req_instruction[winner];
            imm_q   <= req_imm12[winner];
            mask_q  <= req_mask[winner];
            win_q   <= winner;
            for (int unsigned l = 0; l < THREADS_PER_WARP; l++) begin
              rs1_q[l] <= req_rs1[winner][l];
              rs2_q[l] <= req_rs2[winner][l];
            end
            rr_ptr <= (winner == WARP_ID_W'(NUM_WARPS - 1)) ? '0 : winner + WARP_ID_W'(1);
            state  <= EXEC;
          end
        end
        EXEC: state <= CAPT;
        CAPT: begin
          // Inactive lanes may carry stale lane output; force them to zero.
          for (int unsigned l = 0; l < THREADS_PER_WARP; l++)
            resp_data[l] <= mask_q[l] ? alu_out[l] : '0;
          resp_warp   <= win_q;
          resp_mask   <= mask_q;
          issue_count <= issue_count + 32'd1;
          state       <= RESP;
        end
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter: a 4-warp and a 3-warp instance,
// each driven by a registered lane model and checked by its own monitor.
module tb_alu_issue_arbiter;
  import alu_issue_arbiter_pkg::*;

  localparam int unsigned T = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  logic        done4    = 1'b0;
  logic        done3    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]      warp;
    logic [T-1:0]    mask;
    logic [T*32-1:0] data;
    logic [31:0]     count;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [T*32-1:0] pack(input data_t d [T]);
    logic [T*32-1:0] p;
    for (int l = 0; l < T; l++) p[l*32 +: 32] = d[l];
    return p;
  endfunction

  function automatic data_t lane_f(input alu_instruction_t op, input data_t a, input data_t b,
                                   input imm12_t imm);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_ADDI: return a + {{20{imm[11]}}, imm};
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      default:  return '0;
    endcase
  endfunction

  // ---------------- 4-warp instance ----------------
  logic             reset4;
  logic [3:0]       req_valid4, req_ready4;
  alu_instruction_t req_instr4 [4];
  imm12_t           req_imm4 [4];
  logic [T-1:0]     req_mask4 [4];
  data_t            req_rs1_4 [4][T];
  data_t            req_rs2_4 [4][T];
  logic [T-1:0]     alu_en4;
  alu_instruction_t alu_instr4;
  imm12_t           alu_imm4;
  data_t            alu_rs1_4 [T], alu_rs2_4 [T], alu_out4 [T];
  logic             resp_valid4, resp_ready4;
  logic [1:0]       resp_warp4;
  logic [T-1:0]     resp_mask4;
  data_t            resp_data4 [T];
  logic [31:0]      cnt4;

  alu_issue_arbiter #(.NUM_WARPS(4), .THREADS_PER_WARP(T), .WARP_ID_W(2)) dut4 (
    .clk(clk), .reset(reset4),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .req_instruction(req_instr4), .req_imm12(req_imm4), .req_mask(req_mask4),
    .req_rs1(req_rs1_4), .req_rs2(req_rs2_4),
    .alu_enable(alu_en4), .alu_instruction(alu_instr4), .alu_imm12(alu_imm4),
    .alu_rs1(alu_rs1_4), .alu_rs2(alu_rs2_4), .alu_out(alu_out4),
    .resp_valid(resp_valid4), .resp_ready(resp_ready4), .resp_warp(resp_warp4),
    .resp_mask(resp_mask4), .resp_data(resp_data4), .issue_count(cnt4)
  );

  // Lane model: registered result; disabled lanes present junk.
  always_ff @(posedge clk)
    for (int l = 0; l < T; l++)
      alu_out4[l] <= alu_en4[l] ? lane_f(alu_instr4, alu_rs1_4[l], alu_rs2_4[l], alu_imm4)
                                : 32'hDEAD_BEEF;

  // ---------------- 3-warp instance ----------------
  logic             reset3;
  logic [2:0]       req_valid3, req_ready3;
  alu_instruction_t req_instr3 [3];
  imm12_t           req_imm3 [3];
  logic [T-1:0]     req_mask3 [3];
  data_t            req_rs1_3 [3][T];
  data_t            req_rs2_3 [3][T];
  logic [T-1:0]     alu_en3;
  alu_instruction_t alu_instr3;
  imm12_t           alu_imm3;
  data_t            alu_rs1_3 [T], alu_rs2_3 [T], alu_out3 [T];
  logic             resp_valid3, resp_ready3;
  logic [1:0]       resp_warp3;
  logic [T-1:0]     resp_mask3;
  data_t            resp_data3 [T];
  logic [31:0]      cnt3;

  alu_issue_arbiter #(.NUM_WARPS(3), .THREADS_PER_WARP(T), .WARP_ID_W(2)) dut3 (
    .clk(clk), .reset(reset3),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_instruction(req_instr3), .req_imm12(req_imm3), .req_mask(req_mask3),
    .req_rs1(req_rs1_3), .req_rs2(req_rs2_3),
    .alu_enable(alu_en3), .alu_instruction(alu_instr3), .alu_imm12(alu_imm3),
    .alu_rs1(alu_rs1_3), .alu_rs2(alu_rs2_3), .alu_out(alu_out3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_warp(resp_warp3),
    .resp_mask(resp_mask3), .resp_data(resp_data3), .issue_count(cnt3)
  );

  always_ff @(posedge clk)
    for (int l = 0; l < T; l++)
      alu_out3[l] <= alu_en3[l] ? lane_f(alu_instr3, alu_rs1_3[l], alu_rs2_3[l], alu_imm3)
                                : 32'hDEAD_BEEF;

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (resp_valid4 && resp_ready4) begin
      if (q4.size() == 0) begin
        n_checks++;
        $display("FAIL dut4 unexpected response: warp %0d data %0h", resp_warp4, pack(resp_data4));
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("dut4 resp_warp", resp_warp4, e.warp);
        chk("dut4 resp_mask", resp_mask4, e.mask);
        chk("dut4 resp_data", pack(resp_data4), e.data);
        chk("dut4 issue_count", cnt4, e.count);
      end
    end
  end

  always @(negedge clk) begin
    if (resp_valid3 && resp_ready3) begin
      if (q3.size() == 0) begin
        n_checks++;
        $display("FAIL dut3 unexpected response: warp %0d data %0h", resp_warp3, pack(resp_data3));
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("dut3 resp_warp", resp_warp3, e.warp);
        chk("dut3 resp_mask", resp_mask3, e.mask);
        chk("dut3 resp_data", pack(resp_data3), e.data);
        chk("dut3 issue_count", cnt3, e.count);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic set4(input int w, input alu_instruction_t op, input data_t a, input data_t b,
                      input imm12_t imm, input logic [T-1:0] m);
    req_instr4[w] = op;
    req_imm4[w]   = imm;
    req_mask4[w]  = m;
    for (int l = 0; l < T; l++) begin
      req_rs1_4[w][l] = a;
      req_rs2_4[w][l] = b;
    end
    req_valid4[w] = 1'b1;
  endtask

  task automatic set3(input int w, input alu_instruction_t op, input data_t a, input data_t b);
    req_instr3[w] = op;
    req_imm3[w]   = '0;
    req_mask3[w]  = '1;
    for (int l = 0; l < T; l++) begin
      req_rs1_3[w][l] = a;
      req_rs2_3[w][l] = b;
    end
    req_valid3[w] = 1'b1;
  endtask

  task automatic push(input bit to4, input logic [1:0] w, input logic [T-1:0] m,
                      input logic [T*32-1:0] d, input logic [31:0] c);
    exp_t e;
    e.warp = w; e.mask = m; e.data = d; e.count = c;
    if (to4) q4.push_back(e);
    else     q3.push_back(e);
  endtask

  task automatic wait_grant4(input logic [3:0] exp_oh, input string name);
    int n = 0;
    @(negedge clk);
    while (req_ready4 == '0 && n < 20) begin @(negedge clk); n++; end
    chk(name, req_ready4, exp_oh);
  endtask

  task automatic wait_grant3(input logic [2:0] exp_oh, input string name);
    int n = 0;
    @(negedge clk);
    while (req_ready3 == '0 && n < 20) begin @(negedge clk); n++; end
    chk(name, req_ready3, exp_oh);
  endtask

  task automatic drain4(input string name);
    int n = 0;
    while (q4.size() != 0 && n < 40) begin @(negedge clk); n++; end
    chk(name, q4.size(), 0);
  endtask

  // ---------------- 4-warp stimulus ----------------
  initial begin
    data_t fair_d [4];
    int    last;
    fair_d = '{32'd10, 32'd21, 32'd32, 32'd43};
    reset4 = 1'b1; req_valid4 = '0; resp_ready4 = 1'b1;
    for (int w = 0; w < 4; w++) begin
      set4(w, ALU_ADD, 0, 0, 0, '0);
    end
    req_valid4 = '0;
    tick(); tick();
    @(negedge clk);
    chk("reset req_ready", req_ready4, 0);
    chk("reset alu_enable", alu_en4, 0);
    chk("reset resp_valid", resp_valid4, 0);
    chk("reset resp_warp", resp_warp4, 0);
    chk("reset resp_mask", resp_mask4, 0);
    chk("reset resp_data", pack(resp_data4), 0);
    chk("reset issue_count", cnt4, 0);
    tick();
    reset4 = 1'b0;

    // single request, warp 2, ADD 5+7
    set4(2, ALU_ADD, 5, 7, 0, 4'hF);
    push(1, 2, 4'hF, {4{32'd12}}, 1);
    wait_grant4(4'b0100, "single grant");
    tick(); req_valid4[2] = 1'b0;
    tick();
    @(negedge clk); chk("single resp_valid in CAPT", resp_valid4, 0);
    tick();
    @(negedge clk); chk("single resp_valid at cycle 3", resp_valid4, 1);
    drain4("single drain"); tick();

    // masked lanes, warp 1, ADDI 10 + (-3)
    set4(1, ALU_ADDI, 10, 0, 12'hFFD, 4'b0101);
    push(1, 1, 4'b0101, {32'd0, 32'd7, 32'd0, 32'd7}, 2);
    wait_grant4(4'b0010, "masked grant");
    tick(); req_valid4[1] = 1'b0;
    @(negedge clk);
    chk("masked alu_enable", alu_en4, 4'b0101);
    chk("masked alu_instruction", alu_instr4, ALU_ADDI);
    chk("masked alu_imm12", alu_imm4, 12'hFFD);
    drain4("masked drain"); tick();

    // idle reset returns rr_ptr and issue_count to 0
    reset4 = 1'b1; tick(); reset4 = 1'b0;
    @(negedge clk); chk("idle reset issue_count", cnt4, 0);
    tick();

    // fairness: all four warps continuously valid
    for (int w = 0; w < 4; w++) set4(w, ALU_ADD, data_t'(10 * (w + 1)), data_t'(w), 0, 4'hF);
    for (int i = 0; i < 6; i++) push(1, 2'(i % 4), 4'hF, {4{fair_d[i % 4]}}, 32'(i + 1));
    last = 0;
    for (int i = 0; i < 6; i++) begin
      wait_grant4(4'(1 << (i % 4)), "fair grant order");
      if (i > 0) chk("fair grant spacing", cyc - last, 4);
      last = cyc;
      tick();
    end
    req_valid4 = '0;
    drain4("fair drain"); tick();

    // backpressure: warp 0 response held, warp 3 waits
    resp_ready4 = 1'b0;
    set4(0, ALU_SUB, 100, 1, 0, 4'hF);
    push(1, 0, 4'hF, {4{32'd99}}, 7);
    wait_grant4(4'b0001, "bp grant");
    tick(); req_valid4[0] = 1'b0;
    set4(3, ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 0, 4'hF);
    push(1, 3, 4'hF, {4{32'h0000_FF00}}, 8);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp resp_valid held", resp_valid4, 1);
      chk("bp resp_data held", pack(resp_data4), {4{32'd99}});
      chk("bp req_ready blocked", req_ready4, 0);
      tick();
    end
    resp_ready4 = 1'b1;
    @(negedge clk); chk("bp req_ready at handshake", req_ready4, 0);
    tick();
    @(negedge clk); chk("bp grant after handshake", req_ready4, 4'b1000);
    tick(); req_valid4[3] = 1'b0;
    drain4("bp drain"); tick();

    // reset during EXEC discards the op and rr_ptr
    set4(1, ALU_ADD, 1, 1, 0, 4'hF);
    wait_grant4(4'b0010, "pre-reset grant");
    tick(); req_valid4[1] = 1'b0; reset4 = 1'b1;
    @(negedge clk); chk("exec before reset", alu_en4, 4'hF);
    tick(); reset4 = 1'b0;
    @(negedge clk);
    chk("post-reset resp_valid", resp_valid4, 0);
    chk("post-reset alu_enable", alu_en4, 0);
    chk("post-reset issue_count", cnt4, 0);
    tick();
    set4(1, ALU_ADD, 2, 3, 0, 4'hF);
    set4(3, ALU_OR, 32'h00F0, 32'h000F, 0, 4'b0000);
    push(1, 1, 4'hF, {4{32'd5}}, 1);
    push(1, 3, 4'b0000, '0, 2);
    wait_grant4(4'b0010, "post-reset grant lowest");
    tick(); req_valid4[1] = 1'b0;
    wait_grant4(4'b1000, "zero-mask grant");
    tick(); req_valid4[3] = 1'b0;
    @(negedge clk); chk("zero-mask alu_enable", alu_en4, 0);
    drain4("final drain");
    done4 = 1'b1;
  end

  // ---------------- 3-warp stimulus ----------------
  initial begin
    reset3 = 1'b1; req_valid3 = '0; resp_ready3 = 1'b1;
    for (int w = 0; w < 3; w++) set3(w, ALU_SUB, 3, 5);
    req_valid3 = '0;
    tick(); tick();
    reset3 = 1'b0;
    for (int w = 0; w < 3; w++) set3(w, ALU_SUB, 3, 5);
    for (int i = 0; i < 4; i++) push(0, 2'(i % 3), 4'hF, {4{32'hFFFF_FFFE}}, 32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      wait_grant3(3'(1 << (i % 3)), "n3 grant order");
      tick();
    end
    req_valid3 = '0;
    begin
      int n = 0;
      while (q3.size() != 0 && n < 40) begin @(negedge clk); n++; end
      chk("n3 drain", q3.size(), 0);
    end
    done3 = 1'b1;
  end

  // ---------------- summary ----------------
  initial begin
    int n = 0;
    while (!(done4 && done3) && n < 5000) begin @(negedge clk); n++; end
    if (!(done4 && done3)) begin
      n_checks++;
      $display("FAIL run timeout: done4=%0d done3=%0d", done4, done3);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
